// File: rtl/adbg_halt_pkg.sv
// Shared encodings for the multi-core run/halt controller:
// per-core states, halt reasons and host command opcodes.
package adbg_halt_pkg;

  typedef enum logic [1:0] {
    STATE_RUN     = 2'd0,
    STATE_HALTING = 2'd1,
    STATE_HALTED  = 2'd2,
    STATE_STEP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REASON_BP    = 2'd0,
    REASON_STEP  = 2'd1,
    REASON_HOST  = 2'd2,
    REASON_GROUP = 2'd3
  } reason_t;

  // Opcodes 5-7 are reserved and decode as NOP.
  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_HALT      = 3'd1,
    OP_RESUME    = 3'd2,
    OP_STEP      = 3'd3,
    OP_SET_GROUP = 3'd4
  } op_t;

endpackage

// File: rtl/adbg_halt_core_fsm.sv
// One core's run/halt state machine: state, latched halt reason,
// single-step counter, stall request and halted-event pulse.
module adbg_halt_core_fsm
  import adbg_halt_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              cpu_clk_i,
  input  logic              cpu_rstn_i,
  input  logic              bp_i,
  input  logic              halted_i,
  input  logic              retire_i,
  input  logic              halt_req_i,
  input  logic              resume_req_i,
  input  logic              step_req_i,
  input  logic [STEP_W-1:0] step_arg_i,
  input  logic              group_trig_i,
  output logic [1:0]        state_o,
  output logic [1:0]        reason_o,
  output logic              stall_o,
  output logic              halt_evt_o,
  output logic              bp_trig_o,
  output logic              halting_o
);

  localparam logic [1:0] S_RUN     = STATE_RUN;
  localparam logic [1:0] S_HALTING = STATE_HALTING;
  localparam logic [1:0] S_HALTED  = STATE_HALTED;
  localparam logic [1:0] S_STEP    = STATE_STEP;

  localparam logic [1:0] R_BP    = REASON_BP;
  localparam logic [1:0] R_STEP  = REASON_STEP;
  localparam logic [1:0] R_HOST  = REASON_HOST;
  localparam logic [1:0] R_GROUP = REASON_GROUP;

  localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        reason_q, reason_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              evt_q, evt_d;
  logic              bp_trig_q, bp_trig_d;
  logic              enter;
  logic [1:0]        why;
  logic              step_done;

  always_comb begin
    state_d   = state_q;
    reason_d  = reason_q;
    cnt_d     = cnt_q;
    evt_d     = 1'b0;
    bp_trig_d = 1'b0;
    enter     = 1'b0;
    why       = R_GROUP;
    step_done = (state_q == S_STEP) && retire_i && (cnt_q == CNT_ONE);

    case (state_q)
      S_RUN, S_STEP: begin
        if (state_q == S_STEP && retire_i) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        // Halt causes are tested in reason priority order: BP > STEP > HOST > GROUP.
        if (bp_i) begin
          enter = 1'b1;
          why   = R_BP;
        end else if (step_done) begin
          enter = 1'b1;
          why   = R_STEP;
        end else if (halt_req_i) begin
          enter = 1'b1;
          why   = R_HOST;
        end else if (group_trig_i) begin
          enter = 1'b1;
          why   = R_GROUP;
        end
      end
      S_HALTING: begin
        if (halted_i) begin
          state_d = S_HALTED;
          evt_d   = 1'b1;
        end
      end
      default: begin
        if (resume_req_i) begin
          state_d = S_RUN;
        end else if (step_req_i) begin
          state_d = S_STEP;
          cnt_d   = (step_arg_i == '0) ? CNT_ONE : step_arg_i;
        end
      end
    endcase

    if (enter) begin
      state_d   = S_HALTING;
      reason_d  = why;
      bp_trig_d = (why == R_BP);
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      state_q   <= S_RUN;
      reason_q  <= R_BP;
      cnt_q     <= '0;
      evt_q     <= 1'b0;
      bp_trig_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reason_q  <= reason_d;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
      bp_trig_q <= bp_trig_d;
    end
  end

  // A running core stalls on a breakpoint in the same cycle, before the FSM reacts.
  assign stall_o    = (state_q == S_HALTING || state_q == S_HALTED) ? 1'b1 : bp_i;
  assign state_o    = state_q;
  assign reason_o   = reason_q;
  assign halt_evt_o = evt_q;
  assign bp_trig_o  = bp_trig_q;
  assign halting_o  = (state_q == S_HALTING);

endmodule

// File: rtl/adbg_multicore_halt_ctrl.sv
// Multi-core run/halt controller: host command decode, ready generation,
// halt-group registers and breakpoint cross-triggering around per-core FSMs.
module adbg_multicore_halt_ctrl
  import adbg_halt_pkg::*;
#(
  parameter int NB_CORES  = 4,
  parameter int NB_GROUPS = 2,
  parameter int STEP_W    = 8
) (
  input  logic                  cpu_clk_i,
  input  logic                  cpu_rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_op_i,
  input  logic [NB_CORES-1:0]   cmd_mask_i,
  input  logic [STEP_W-1:0]     cmd_arg_i,
  input  logic [NB_CORES-1:0]   bp_i,
  input  logic [NB_CORES-1:0]   halted_i,
  input  logic [NB_CORES-1:0]   retire_i,
  output logic [NB_CORES-1:0]   cpu_stall_o,
  output logic [2*NB_CORES-1:0] state_o,
  output logic [2*NB_CORES-1:0] reason_o,
  output logic [NB_CORES-1:0]   halt_evt_o
);

  localparam int GI_W = (STEP_W < 3) ? STEP_W : 3;

  logic [NB_GROUPS-1:0][NB_CORES-1:0] group_q, group_d;
  logic [NB_CORES-1:0] halting_vec;
  logic [NB_CORES-1:0] bp_trig;
  logic [NB_CORES-1:0] group_trig;
  logic [NB_CORES-1:0] halt_req, resume_req, step_req;
  logic [GI_W-1:0]     grp_idx;
  logic                is_ctrl_op;
  logic                cmd_fire;

  assign grp_idx = cmd_arg_i[GI_W-1:0];

  // Control ops to a core still waiting for its halted ack are back-pressured.
  always_comb begin
    is_ctrl_op  = (cmd_op_i == OP_HALT) || (cmd_op_i == OP_RESUME) || (cmd_op_i == OP_STEP);
    cmd_ready_o = !(is_ctrl_op && |(cmd_mask_i & halting_vec));
    cmd_fire    = cmd_valid_i && cmd_ready_o;
    halt_req    = (cmd_fire && cmd_op_i == OP_HALT)   ? cmd_mask_i : '0;
    resume_req  = (cmd_fire && cmd_op_i == OP_RESUME) ? cmd_mask_i : '0;
    step_req    = (cmd_fire && cmd_op_i == OP_STEP)   ? cmd_mask_i : '0;
  end

  always_comb begin
    group_d = group_q;
    if (cmd_fire && cmd_op_i == OP_SET_GROUP) begin
      for (int g = 0; g < NB_GROUPS; g++) begin
        if (int'(grp_idx) == g) begin
          group_d[g] = cmd_mask_i;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      group_q <= '0;
    end else begin
      group_q <= group_d;
    end
  end

  // bp_trig is already one cycle behind the BP entry, giving peers their n+2 halt.
  always_comb begin
    group_trig = '0;
    for (int k = 0; k < NB_CORES; k++) begin
      for (int j = 0; j < NB_CORES; j++) begin
        for (int g = 0; g < NB_GROUPS; g++) begin
          if (j != k && bp_trig[j] && group_q[g][j] && group_q[g][k]) begin
            group_trig[k] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    adbg_halt_core_fsm #(
      .STEP_W (STEP_W)
    ) u_fsm (
      .cpu_clk_i    (cpu_clk_i),
      .cpu_rstn_i   (cpu_rstn_i),
      .bp_i         (bp_i[i]),
      .halted_i     (halted_i[i]),
      .retire_i     (retire_i[i]),
      .halt_req_i   (halt_req[i]),
      .resume_req_i (resume_req[i]),
      .step_req_i   (step_req[i]),
      .step_arg_i   (cmd_arg_i),
      .group_trig_i (group_trig[i]),
      .state_o      (state_o[2*i +: 2]),
      .reason_o     (reason_o[2*i +: 2]),
      .stall_o      (cpu_stall_o[i]),
      .halt_evt_o   (halt_evt_o[i]),
      .bp_trig_o    (bp_trig[i]),
      .halting_o    (halting_vec[i])
    );
  end

endmodule

// File: tb/tb_adbg_multicore_halt_ctrl.sv
// Self-checking bench for adbg_multicore_halt_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_adbg_multicore_halt_ctrl;

  localparam int NB = 4;
  localparam int NG = 2;
  localparam int SW = 8;

  localparam int RUN = 0, HALTING = 1, HALTED = 2, STEP = 3;
  localparam int R_BP = 0, R_STEP = 1, R_HOST = 2, R_GROUP = 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [NB-1:0]   cmd_mask;
  logic [SW-1:0]   cmd_arg;
  logic [NB-1:0]   bp, halted, retire;
  logic [NB-1:0]   stall;
  logic [2*NB-1:0] state_o, reason_o;
  logic [NB-1:0]   evt;

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;

  int            m_state  [NB];
  int            m_reason [NB];
  int            m_cnt    [NB];
  bit            m_evt    [NB];
  logic [NB-1:0] m_group  [NG];
  int            bp_prev  [$];

  adbg_multicore_halt_ctrl #(
    .NB_CORES  (NB),
    .NB_GROUPS (NG),
    .STEP_W    (SW)
  ) dut (
    .cpu_clk_i   (clk),
    .cpu_rstn_i  (rstn),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_mask_i  (cmd_mask),
    .cmd_arg_i   (cmd_arg),
    .bp_i        (bp),
    .halted_i    (halted),
    .retire_i    (retire),
    .cpu_stall_o (stall),
    .state_o     (state_o),
    .reason_o    (reason_o),
    .halt_evt_o  (evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] dut_st(input int k);
    return state_o[2*k +: 2];
  endfunction

  function automatic logic [1:0] dut_rs(input int k);
    return reason_o[2*k +: 2];
  endfunction

  // ---------------- behavioural model ----------------
  function automatic void model_reset();
    for (int k = 0; k < NB; k++) begin
      m_state[k] = RUN; m_reason[k] = R_BP; m_cnt[k] = 0; m_evt[k] = 1'b0;
    end
    for (int g = 0; g < NG; g++) m_group[g] = '0;
    bp_prev.delete();
  endfunction

  function automatic bit model_ready();
    if (cmd_op == 3'd1 || cmd_op == 3'd2 || cmd_op == 3'd3)
      for (int k = 0; k < NB; k++)
        if (cmd_mask[k] && m_state[k] == HALTING) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit shares(input int j, input int k);
    for (int g = 0; g < NG; g++)
      if (m_group[g][j] && m_group[g][k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step();
    int nxt_bp [$];
    bit acc;
    bit trig [NB];
    int best;
    acc = cmd_valid && model_ready();
    foreach (trig[k]) trig[k] = 1'b0;
    foreach (bp_prev[q])
      for (int k = 0; k < NB; k++)
        if (k != bp_prev[q] && shares(bp_prev[q], k)) trig[k] = 1'b1;
    for (int k = 0; k < NB; k++) begin
      m_evt[k] = 1'b0;
      if (m_state[k] == RUN || m_state[k] == STEP) begin
        // lowest reason code among the active causes wins
        best = 4;
        if (trig[k]) best = R_GROUP;
        if (acc && cmd_op == 3'd1 && cmd_mask[k]) best = R_HOST;
        if (m_state[k] == STEP && retire[k] && m_cnt[k] == 1) best = R_STEP;
        if (bp[k]) best = R_BP;
        if (m_state[k] == STEP && retire[k]) m_cnt[k] = m_cnt[k] - 1;
        if (best < 4) begin
          m_state[k] = HALTING;
          m_reason[k] = best;
          if (best == R_BP) nxt_bp.push_back(k);
        end
      end else if (m_state[k] == HALTING) begin
        if (halted[k]) begin
          m_state[k] = HALTED;
          m_evt[k] = 1'b1;
        end
      end else begin
        if (acc && cmd_op == 3'd2 && cmd_mask[k]) m_state[k] = RUN;
        else if (acc && cmd_op == 3'd3 && cmd_mask[k]) begin
          m_state[k] = STEP;
          m_cnt[k] = (cmd_arg == 0) ? 1 : int'(cmd_arg);
        end
      end
    end
    if (acc && cmd_op == 3'd4 && int'(cmd_arg[2:0]) < NG) m_group[int'(cmd_arg[2:0])] = cmd_mask;
    bp_prev = nxt_bp;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [2*NB-1:0] e_state, e_reason;
  logic [NB-1:0]   e_stall, e_evt;

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < NB; k++) begin
        e_state[2*k +: 2]  = 2'(m_state[k]);
        e_reason[2*k +: 2] = 2'(m_reason[k]);
        e_stall[k] = (m_state[k] == HALTING || m_state[k] == HALTED) ? 1'b1 : bp[k];
        e_evt[k]   = m_evt[k];
      end
      chk("cmp_state",  32'(state_o),   32'(e_state));
      chk("cmp_reason", 32'(reason_o),  32'(e_reason));
      chk("cmp_stall",  32'(stall),     32'(e_stall));
      chk("cmp_evt",    32'(evt),       32'(e_evt));
      chk("cmp_ready",  32'(cmd_ready), 32'(model_ready()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = '0; cmd_arg = '0;
    bp = '0; halted = '0; retire = '0;
  endtask

  task automatic applyCmd(input logic [2:0] op, input logic [NB-1:0] mask, input logic [SW-1:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_arg = arg;
  endtask

  task automatic releaseAll();
    tick(); applyIdle(); halted = '1;
    repeat (3) tick();
    halted = '0; applyCmd(3'd2, '1, '0);
    tick(); applyIdle();
    tick();
  endtask

  initial begin
    applyIdle();
    model_reset();
    bp = 4'b1001;
    @(negedge clk);
    check_en = 1'b1;
    chk("rst_state",  32'(state_o),   32'h0);
    chk("rst_reason", 32'(reason_o),  32'h0);
    chk("rst_stall",  32'(stall),     32'h9);
    chk("rst_evt",    32'(evt),       32'h0);
    chk("rst_ready",  32'(cmd_ready), 32'h1);
    tick(); rstn = 1'b1; bp = '0;
    tick();

    // breakpoint on core1, late halted ack
    bp = 4'b0010;
    @(negedge clk);
    chk("bp_stall_same_cycle", 32'(stall[1]), 32'h1);
    chk("bp_state_before", 32'(dut_st(1)), RUN);
    tick(); bp = '0;
    @(negedge clk);
    chk("bp_halting", 32'(dut_st(1)), HALTING);
    chk("bp_reason",  32'(dut_rs(1)), R_BP);
    chk("bp_stall_held", 32'(stall[1]), 32'h1);
    tick(); tick(); halted = 4'b0010;
    @(negedge clk);
    chk("bp_wait_ack", 32'(dut_st(1)), HALTING);
    chk("bp_no_evt",   32'(evt), 32'h0);
    tick(); halted = '0;
    @(negedge clk);
    chk("bp_halted", 32'(dut_st(1)), HALTED);
    chk("bp_evt",    32'(evt), 32'h2);
    tick();
    @(negedge clk);
    chk("bp_evt_once", 32'(evt), 32'h0);
    applyCmd(3'd2, 4'b0010, '0);
    @(negedge clk);
    chk("resume_ready", 32'(cmd_ready), 32'h1);
    tick(); applyIdle();
    @(negedge clk);
    chk("resume_run", 32'(dut_st(1)), RUN);

    // group {0,2} cross-trigger
    tick(); applyCmd(3'd4, 4'b0101, 8'd0);
    tick(); applyIdle(); bp = 4'b0001;
    tick(); bp = '0;
    @(negedge clk);
    chk("grp_src_halting", 32'(dut_st(0)), HALTING);
    chk("grp_peer_not_yet", 32'(dut_st(2)), RUN);
    tick();
    @(negedge clk);
    chk("grp_peer_halting", 32'(dut_st(2)), HALTING);
    chk("grp_peer_reason",  32'(dut_rs(2)), R_GROUP);
    chk("grp_others_run",   32'({dut_st(3), dut_st(1)}), 32'h0);
    releaseAll();

    // single step on core3, arg=3 then arg=0
    applyCmd(3'd1, 4'b1000, '0);
    tick(); applyIdle(); halted = 4'b1000;
    tick(); halted = '0;
    @(negedge clk);
    chk("step_pre_halted", 32'(dut_st(3)), HALTED);
    applyCmd(3'd3, 4'b1000, 8'd3);
    tick(); applyIdle();
    @(negedge clk);
    chk("step_state", 32'(dut_st(3)), STEP);
    chk("step_stall_low", 32'(stall[3]), 32'h0);
    for (int p = 0; p < 3; p++) begin
      tick(); retire = 4'b1000;
      tick(); retire = '0;
      @(negedge clk);
      if (p < 2) chk("step_still_running", 32'(dut_st(3)), STEP);
      else begin
        chk("step_done_halting", 32'(dut_st(3)), HALTING);
        chk("step_reason", 32'(dut_rs(3)), R_STEP);
      end
    end
    halted = 4'b1000;
    tick(); halted = '0;
    applyCmd(3'd3, 4'b1000, 8'd0);
    tick(); applyIdle();
    @(negedge clk);
    chk("step0_state", 32'(dut_st(3)), STEP);
    tick(); retire = 4'b1000;
    tick(); retire = '0;
    @(negedge clk);
    chk("step0_halting", 32'(dut_st(3)), HALTING);
    chk("step0_reason", 32'(dut_rs(3)), R_STEP);
    releaseAll();

    // back-pressure while core1 is HALTING
    applyCmd(3'd1, 4'b0010, '0);
    tick(); applyCmd(3'd1, 4'b0110, '0);
    @(negedge clk);
    chk("bpress_ready0", 32'(cmd_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("bpress_core2_run", 32'(dut_st(2)), RUN);
    tick(); halted = 4'b0010;
    @(negedge clk);
    chk("bpress_ready_still0", 32'(cmd_ready), 32'h0);
    tick(); halted = '0;
    @(negedge clk);
    chk("bpress_ready1", 32'(cmd_ready), 32'h1);
    tick(); applyIdle();
    @(negedge clk);
    chk("bpress_core2_halting", 32'(dut_st(2)), HALTING);
    chk("bpress_core2_reason",  32'(dut_rs(2)), R_HOST);
    chk("bpress_core1_halted",  32'(dut_st(1)), HALTED);
    releaseAll();

    // HALT and bp together; RESUME to a running core
    applyCmd(3'd1, 4'b0001, '0); bp = 4'b0001;
    tick(); applyIdle();
    @(negedge clk);
    chk("prio_reason_bp", 32'(dut_rs(0)), R_BP);
    applyCmd(3'd2, 4'b0010, '0);
    tick(); applyIdle();
    @(negedge clk);
    chk("resume_run_core_noop", 32'(dut_st(1)), RUN);
    releaseAll();

    // out-of-range group index is ignored
    applyCmd(3'd4, 4'b1111, 8'd2);
    tick(); applyIdle(); bp = 4'b0010;
    tick(); bp = '0;
    tick();
    @(negedge clk);
    chk("grpidx_core1_halting", 32'(dut_st(1)), HALTING);
    chk("grpidx_core3_run", 32'(dut_st(3)), RUN);
    chk("grpidx_core0_run", 32'(dut_st(0)), RUN);
    releaseAll();

    // asynchronous reset mid-operation
    applyCmd(3'd1, 4'b1010, '0);
    tick(); applyIdle(); halted = 4'b1010;
    tick(); halted = '0; applyCmd(3'd3, 4'b1000, 8'd5);
    tick(); applyIdle();
    @(negedge clk);
    chk("prerst_core3_step", 32'(dut_st(3)), STEP);
    tick(); rstn = 1'b0; bp = 4'b0100;
    #1;
    chk("arst_state",  32'(state_o),   32'h0);
    chk("arst_stall",  32'(stall),     32'h4);
    chk("arst_reason", 32'(reason_o),  32'h0);
    chk("arst_ready",  32'(cmd_ready), 32'h1);
    tick(); rstn = 1'b1; bp = '0;
    tick(); bp = 4'b0001;
    tick(); bp = '0;
    tick();
    @(negedge clk);
    chk("arst_groups_cleared", 32'(dut_st(2)), RUN);
    releaseAll();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 499) == 0) rstn = 1'b0;
      for (int k = 0; k < NB; k++) begin
        bp[k]     = ($urandom_range(0, 15) == 0);
        halted[k] = ($urandom_range(0, 2) == 0);
        retire[k] = ($urandom_range(0, 2) == 0);
      end
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_mask  = NB'($urandom);
      cmd_arg   = (cmd_op == 3'd4) ? SW'($urandom_range(0, 3)) : SW'($urandom_range(0, 5));
    end
    tick(); applyIdle(); rstn = 1'b1;
    tick();
    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
